// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer
// Autonomous note sequencer for the Karplus-Strong string voice. It steps through a
// small programmable table of string periods, one step every L sample ticks. Each step
// damps the string for one tick (MUTE), loads the period, then plucks for PLUCK_TICKS
// ticks (PLUCK) and waits out the rest of the step (HOLD).
//
// Optional build macro: KS_SEQ_SWING_EN adds swing_i. When swing_i=1, odd-indexed
// steps last L + (L>>2) ticks.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   tick_i          sample-rate strobe, one clk wide
//   run_i           1 = run the sequence, 0 = stop (acts on every clk)
//   one_shot_i      1 = stop after the last step, 0 = loop
//   tempo_i         step length in ticks (clamped to PLUCK_TICKS+2 minimum)
//   last_step_i     index of the final step
//   step_we_i, step_addr_i, step_period_i, step_rest_i   table write port
//   period_o        period to ks_string
//   pluck_o         pluck request to ks_string
//   rst_string_no   active-low string damp
//   step_idx_o      index of the current step
//   busy_o          1 when not idle
//   wrap_o          one-clk pulse when the sequence passes its last step
module ks_note_sequencer #(
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TEMPO_WIDTH = 12,
  parameter int unsigned PLUCK_TICKS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_STEPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_i,
  input  logic                   run_i,
  input  logic                   one_shot_i,
`ifdef KS_SEQ_SWING_EN
  input  logic                   swing_i,
`endif
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic [IDX_W-1:0]       last_step_i,
  input  logic                   step_we_i,
  input  logic [IDX_W-1:0]       step_addr_i,
  input  logic [DATA_WIDTH-1:0]  step_period_i,
  input  logic                   step_rest_i,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic                   pluck_o,
  output logic                   rst_string_no,
  output logic [IDX_W-1:0]       step_idx_o,
  output logic                   busy_o,
  output logic                   wrap_o
);

  typedef enum logic [1:0] {StIdle, StMute, StPluck, StHold} state_e;

  localparam logic [TEMPO_WIDTH-1:0] MinLen   = TEMPO_WIDTH'(PLUCK_TICKS + 2);
  // Counter value on the last PLUCK tick (MUTE tick is counted as 1).
  localparam logic [TEMPO_WIDTH-1:0] PluckEnd = TEMPO_WIDTH'(PLUCK_TICKS + 1);
  localparam logic [TEMPO_WIDTH-1:0] CntMax   = '1;

  logic [DATA_WIDTH-1:0]  tbl_period_q [NUM_STEPS];
  logic [NUM_STEPS-1:0]   tbl_rest_q;

  state_e                 state_q, state_d;
  logic [TEMPO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  period_q, period_d;
  logic                   rest_q, rest_d;
  logic                   pluck_q, pluck_d;
  logic                   rsn_q, rsn_d;
  logic                   wrap_q, wrap_d;
  logic                   busy_q;
  logic                   enter_mute;
  logic [TEMPO_WIDTH-1:0] len, limit;

  // Table: write in any state. A MUTE load on the same clk reads the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl_period_q[i] <= '0;
      tbl_rest_q <= '0;
    end else if (step_we_i) begin
      tbl_period_q[step_addr_i] <= step_period_i;
      tbl_rest_q[step_addr_i]   <= step_rest_i;
    end
  end

  assign len     = (tempo_i < MinLen) ? MinLen : tempo_i;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

`ifdef KS_SEQ_SWING_EN
  logic [TEMPO_WIDTH:0] len_swing;
  assign len_swing = {1'b0, len} + {1'b0, (len >> 2)};
  // Saturated counter could never pass a limit above CntMax, so clamp it.
  assign limit = (swing_i && idx_q[0])
               ? (len_swing[TEMPO_WIDTH] ? CntMax : len_swing[TEMPO_WIDTH-1:0])
               : len;
`else
  assign limit = len;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    period_d   = period_q;
    rest_d     = rest_q;
    pluck_d    = pluck_q;
    rsn_d      = rsn_q;
    wrap_d     = 1'b0;
    enter_mute = 1'b0;
    if (!run_i) begin
      // Stop keeps period and step index so a restart resumes at the same step.
      state_d = StIdle;
      pluck_d = 1'b0;
      rsn_d   = 1'b1;
      cnt_d   = '0;
    end else if (tick_i) begin
      unique case (state_q)
        StIdle: enter_mute = 1'b1;
        StMute: begin
          state_d = StPluck;
          rsn_d   = 1'b1;
          pluck_d = ~rest_q;
          cnt_d   = cnt_inc;
        end
        StPluck: begin
          cnt_d = cnt_inc;
          if (cnt_q >= PluckEnd) begin
            state_d = StHold;
            pluck_d = 1'b0;
          end
        end
        StHold: begin
          if (cnt_q >= limit) begin
            // last_step_i cannot exceed NUM_STEPS-1 as NUM_STEPS is a power of two.
            if (idx_q == last_step_i) begin
              idx_d  = '0;
              wrap_d = 1'b1;
              if (one_shot_i) begin
                state_d = StIdle;
                cnt_d   = '0;
              end else begin
                enter_mute = 1'b1;
              end
            end else begin
              idx_d      = idx_q + 1'b1;
              enter_mute = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
      if (enter_mute) begin
        state_d  = StMute;
        rsn_d    = 1'b0;
        period_d = tbl_period_q[idx_d];
        rest_d   = tbl_rest_q[idx_d];
        cnt_d    = TEMPO_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      period_q <= '0;
      rest_q   <= 1'b0;
      pluck_q  <= 1'b0;
      rsn_q    <= 1'b1;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      rest_q   <= rest_d;
      pluck_q  <= pluck_d;
      rsn_q    <= rsn_d;
      wrap_q   <= wrap_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign period_o      = period_q;
  assign pluck_o       = pluck_q;
  assign rst_string_no = rsn_q;
  assign step_idx_o    = idx_q;
  assign busy_o        = busy_q;
  assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Scoreboard bench for ks_note_sequencer. Expected MUTE events (period, clk gap since the
// previous MUTE or since run was raised), pluck pulse lengths and wrap gaps are queued
// as each scenario is driven; a negedge monitor pops and compares them as they occur.
module tb_ks_note_sequencer;

  localparam int NS = 8;
  localparam int DW = 8;
  localparam int TW = 12;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick_i;
  logic          run_i;
  logic          one_shot_i;
  logic [TW-1:0] tempo_i;
  logic [IW-1:0] last_step_i;
  logic          step_we_i;
  logic [IW-1:0] step_addr_i;
  logic [DW-1:0] step_period_i;
  logic          step_rest_i;
  logic [DW-1:0] period_o;
  logic          pluck_o;
  logic          rst_string_no;
  logic [IW-1:0] step_idx_o;
  logic          busy_o;
  logic          wrap_o;

  ks_note_sequencer #(
    .NUM_STEPS  (NS),
    .DATA_WIDTH (DW),
    .TEMPO_WIDTH(TW),
    .PLUCK_TICKS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick_i),
    .run_i        (run_i),
    .one_shot_i   (one_shot_i),
`ifdef KS_SEQ_SWING_EN
    .swing_i      (1'b0),
`endif
    .tempo_i      (tempo_i),
    .last_step_i  (last_step_i),
    .step_we_i    (step_we_i),
    .step_addr_i  (step_addr_i),
    .step_period_i(step_period_i),
    .step_rest_i  (step_rest_i),
    .period_o     (period_o),
    .pluck_o      (pluck_o),
    .rst_string_no(rst_string_no),
    .step_idx_o   (step_idx_o),
    .busy_o       (busy_o),
    .wrap_o       (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int gap;
  } mute_exp_t;

  mute_exp_t mute_q[$];
  int        pluck_q[$];
  int        wrap_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_mute = 0;
  int mute_len = 0;
  int pluck_len = 0;
  int exp_mute_len = 1;
  int div = 1;
  int phase = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: wrap is handled before MUTE so its gap is measured from the previous MUTE.
  always @(negedge clk) begin
    mute_exp_t e;
    int g;
    if (wrap_o === 1'b1) begin
      check("wrap_expected", int'(wrap_q.size() > 0), 1);
      if (wrap_q.size() > 0) begin
        g = wrap_q.pop_front();
        check("wrap_gap", cyc - last_mute, g);
      end
    end
    if (rst_string_no === 1'b0) begin
      if (mute_len == 0) begin
        check("mute_expected", int'(mute_q.size() > 0), 1);
        if (mute_q.size() > 0) begin
          e = mute_q.pop_front();
          check("mute_period", int'(period_o), e.period);
          check("mute_gap", cyc - last_mute, e.gap);
        end
        last_mute = cyc;
      end
      mute_len++;
    end else if (mute_len > 0) begin
      check("mute_len", mute_len, exp_mute_len);
      mute_len = 0;
    end
    if (pluck_o === 1'b1) begin
      pluck_len++;
    end else if (pluck_len > 0) begin
      check("pluck_expected", int'(pluck_q.size() > 0), 1);
      if (pluck_q.size() > 0) check("pluck_len", pluck_len, pluck_q.pop_front());
      pluck_len = 0;
    end
  end

  task automatic clk_step();
    @(negedge clk);
    tick_i = (phase == 0);
    phase  = (phase + 1 >= div) ? 0 : phase + 1;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic write_step(input int addr, input int period, input logic rest);
    step_we_i     = 1'b1;
    step_addr_i   = IW'(addr);
    step_period_i = DW'(period);
    step_rest_i   = rest;
    clk_step();
    step_we_i = 1'b0;
  endtask

  task automatic push_mute(input int period, input int gap);
    mute_exp_t e;
    e.period = period;
    e.gap    = gap;
    mute_q.push_back(e);
  endtask

  task automatic start_run();
    run_i     = 1'b1;
    last_mute = cyc;
  endtask

  task automatic check_idle(input string tag, input int idx);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_idx"}, int'(step_idx_o), idx);
    check({tag, "_rsn"}, int'(rst_string_no), 1);
    check({tag, "_pluck"}, int'(pluck_o), 0);
  endtask

  task automatic end_test(input string tag);
    run_steps(3);
    check({tag, "_mute_left"}, mute_q.size(), 0);
    check({tag, "_pluck_left"}, pluck_q.size(), 0);
    check({tag, "_wrap_left"}, wrap_q.size(), 0);
    mute_q.delete();
    pluck_q.delete();
    wrap_q.delete();
  endtask

  // Standard three-step one-shot pass: MUTE at +1, +11, +21, wrap at +31.
  task automatic three_step_pass(input string tag, input logic rest1);
    write_step(0, 20, 1'b0);
    write_step(1, 30, rest1);
    write_step(2, 40, 1'b0);
    last_step_i = 3'd2;
    tempo_i     = 12'd10;
    one_shot_i  = 1'b1;
    push_mute(20, 1);
    push_mute(30, 10);
    push_mute(40, 10);
    pluck_q.push_back(4);
    if (!rest1) pluck_q.push_back(4);
    pluck_q.push_back(4);
    wrap_q.push_back(10);
    start_run();
    run_steps(31);
    check({tag, "_wrap_now"}, int'(wrap_o), 1);
    check_idle(tag, 0);
    check({tag, "_period_held"}, int'(period_o), 40);
    run_i = 1'b0;
    end_test(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    tick_i        = 1'b1;
    run_i         = 1'b0;
    one_shot_i    = 1'b1;
    tempo_i       = 12'd10;
    last_step_i   = '0;
    step_we_i     = 1'b0;
    step_addr_i   = '0;
    step_period_i = '0;
    step_rest_i   = 1'b0;

    // Reset values
    run_steps(3);
    rst_n = 1'b1;
    check("rst_period", int'(period_o), 0);
    check("rst_wrap", int'(wrap_o), 0);
    check_idle("rst", 0);

    // Reset mid-step clears the table and all outputs
    write_step(0, 55, 1'b0);
    last_step_i = '0;
    tempo_i     = 12'd6;
    push_mute(55, 1);
    pluck_q.push_back(1);
    start_run();
    run_steps(2);
    rst_n = 1'b0;
    run_i = 1'b0;
    clk_step();
    rst_n = 1'b1;
    check("midrst_period", int'(period_o), 0);
    check("midrst_wrap", int'(wrap_o), 0);
    check_idle("midrst", 0);
    push_mute(0, 1);
    pluck_q.push_back(4);
    wrap_q.push_back(6);
    start_run();
    run_steps(7);
    check_idle("clr", 0);
    run_i = 1'b0;
    end_test("clr");

    // Basic pass, then the same with a rest on step 1
    three_step_pass("basic", 1'b0);
    three_step_pass("rest", 1'b1);

    // Tempo below minimum clamps to 6 ticks
    tempo_i = 12'd2;
    push_mute(20, 1);
    push_mute(30, 6);
    push_mute(40, 6);
    pluck_q.push_back(4);
    pluck_q.push_back(4);
    wrap_q.push_back(6);
    start_run();
    run_steps(19);
    check_idle("clamp", 0);
    run_i = 1'b0;
    end_test("clamp");

    // run_i drop during PLUCK of step 2, then resume at step 2
    write_step(1, 30, 1'b0);
    tempo_i = 12'd10;
    push_mute(20, 1);
    push_mute(30, 10);
    push_mute(40, 10);
    pluck_q.push_back(4);
    pluck_q.push_back(4);
    pluck_q.push_back(2);
    start_run();
    run_steps(23);
    run_i = 1'b0;
    clk_step();
    check_idle("stop", 2);
    check("stop_period", int'(period_o), 40);
    run_steps(2);
    push_mute(40, 1);
    pluck_q.push_back(4);
    wrap_q.push_back(10);
    start_run();
    run_steps(11);
    check_idle("resume", 0);
    run_i = 1'b0;
    end_test("resume");

    // Loop mode at one tick per 3 clks; overwrite step 0 on the clk of its second load
    div          = 3;
    phase        = 0;
    exp_mute_len = 3;
    last_step_i  = 3'd1;
    tempo_i      = 12'd6;
    one_shot_i   = 1'b0;
    push_mute(20, 1);
    push_mute(30, 18);
    push_mute(20, 18);
    push_mute(30, 18);
    push_mute(99, 18);
    for (int i = 0; i < 5; i++) pluck_q.push_back(12);
    wrap_q.push_back(18);
    wrap_q.push_back(18);
    clk_step();
    start_run();
    for (int i = 1; i <= 88; i++) begin
      clk_step();
      if (i == 36) begin
        step_we_i     = 1'b1;
        step_addr_i   = '0;
        step_period_i = 8'd99;
        step_rest_i   = 1'b0;
      end else if (i == 37) begin
        step_we_i = 1'b0;
      end
    end
    run_i = 1'b0;
    clk_step();
    check_idle("loop", 0);
    check("loop_period", int'(period_o), 99);
    end_test("loop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
